key_debouncer: RTL and testbench



---
 rtl/key_debouncer_pkg.sv | 13 +
 rtl/key_debouncer_if.sv | 13 +
 rtl/key_debouncer_cell.sv | 53 +++++
 rtl/key_debouncer.sv | 26 ++
 tb/tb_key_debouncer.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/key_debouncer_pkg.sv
// Shared board timing constants and debounce helpers for the DE0-CV key path.
// Later timer exercises reuse CLK_HZ.
package key_debouncer_pkg;

  localparam int CLK_HZ                  = 50_000_000;
  localparam int DEFAULT_DEBOUNCE_CYCLES = CLK_HZ / 1000;  // 1 ms of stable level

  // Counter width that holds DEBOUNCE_CYCLES-1, never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/key_debouncer_if.sv
// Key-conditioning bus: raw active-low keys in; clean levels and one-cycle edge pulses out.
// Pulses are level-qualified strobes with no back-pressure. "release" is a reserved word, hence release_pulse.
interface key_debouncer_if #(
  parameter int N_KEYS = 4
);
  logic [N_KEYS-1:0] key;
  logic [N_KEYS-1:0] pressed;
  logic [N_KEYS-1:0] press;
  logic [N_KEYS-1:0] release_pulse;

  modport master (output key, input pressed, press, release_pulse);
  modport slave  (input key, output pressed, press, release_pulse);
endinterface

// File: rtl/key_debouncer_cell.sv
// Single-key conditioner: 2-flop synchroniser, stability counter and registered
// pressed level with press/release strobes aligned to the level change.
module key_debounce_cell
  import key_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic pressed,
  output logic press,
  output logic release_pulse
);

  localparam int                 CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic             nk;
  logic             terminal;
  logic [CNT_W-1:0] cnt;

  assign nk       = ~s2;
  assign terminal = (nk != pressed) && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1            <= 1'b1;
      s2            <= 1'b1;
      cnt           <= '0;
      pressed       <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      s1            <= key;
      s2            <= s1;
      press         <= nk & ~pressed & terminal;
      release_pulse <= ~nk & pressed & terminal;
      // Any sample matching the accepted level restarts the stability run.
      if (nk == pressed) begin
        cnt <= '0;
      end else if (cnt != CNT_LAST) begin
        cnt <= cnt + 1'b1;
      end else begin
        pressed <= nk;
        cnt     <= '0;
      end
    end
  end

endmodule

// File: rtl/key_debouncer.sv
// N_KEYS independent debounce cells behind the key_debouncer_if slave modport.
module key_debouncer
  import key_debouncer_pkg::*;
#(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input logic             clk,
  input logic             reset,
  key_debouncer_if.slave  bus
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    key_debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .clk          (clk),
      .reset        (reset),
      .key          (bus.key[i]),
      .pressed      (bus.pressed[i]),
      .press        (bus.press[i]),
      .release_pulse(bus.release_pulse[i])
    );
  end

endmodule

// File: tb/tb_key_debouncer.sv
// Scenario bench for key_debouncer with DEBOUNCE_CYCLES = 4, plus a randomized run
// checked against a sliding-window reference model.
module tb_key_debouncer;
  localparam int N_KEYS = 4;
  localparam int DC     = 4;

  logic              clk   = 1'b0;
  logic              reset = 1'b1;
  logic [N_KEYS-1:0] key   = '1;
  int                checks = 0;
  int                errors = 0;

  key_debouncer_if #(.N_KEYS(N_KEYS)) bus ();
  assign bus.key = key;

  key_debouncer #(
    .N_KEYS         (N_KEYS),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Raw samples pass through a 2-deep delay; a key flips once its last DC delayed
  // samples all disagree with the accepted level, then a fresh window starts.
  logic [N_KEYS-1:0] m_pressed = '0;
  logic [N_KEYS-1:0] m_press   = '0;
  logic [N_KEYS-1:0] m_rel     = '0;
  logic [N_KEYS-1:0] m_delay_q[$];
  bit                m_win[N_KEYS][$];

  always @(posedge clk) begin
    logic [N_KEYS-1:0] nk;
    bit                all_diff;
    if (reset) begin
      m_delay_q = '{'1, '1};
      for (int i = 0; i < N_KEYS; i++) m_win[i].delete();
      m_pressed = '0;
      m_press   = '0;
      m_rel     = '0;
    end else begin
      nk = ~m_delay_q.pop_front();
      m_delay_q.push_back(key);
      m_press = '0;
      m_rel   = '0;
      for (int i = 0; i < N_KEYS; i++) begin
        m_win[i].push_back(nk[i]);
        if (m_win[i].size() > DC) void'(m_win[i].pop_front());
        all_diff = (m_win[i].size() == DC);
        foreach (m_win[i][j]) if (m_win[i][j] == m_pressed[i]) all_diff = 0;
        if (all_diff) begin
          if (m_pressed[i]) m_rel[i] = 1'b1;
          else              m_press[i] = 1'b1;
          m_pressed[i] = ~m_pressed[i];
          m_win[i].delete();
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive_cycle(input logic [N_KEYS-1:0] k, input logic r);
    key   = k;
    reset = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int i = 0; i < 6; i++) begin
      drive_cycle('1, (i < 3));
      checks++;
      if ({bus.pressed, bus.press, bus.release_pulse} !== '0) begin
        errors++;
        $display("FAIL reset_outputs cycle=%0d got pressed=%b press=%b release=%b expected all 0",
                 i, bus.pressed, bus.press, bus.release_pulse);
      end
      checks++;
      if ({bus.pressed, bus.press, bus.release_pulse} !== {m_pressed, m_press, m_rel}) begin
        errors++;
        $display("FAIL reset_model cycle=%0d got %b/%b/%b expected %b/%b/%b", i,
                 bus.pressed, bus.press, bus.release_pulse, m_pressed, m_press, m_rel);
      end
    end
  endtask

  task automatic test_clean_press();
    int rise_at = -1;
    int press_at = -1;
    int n_press = 0;
    for (int i = 1; i <= 10; i++) begin
      drive_cycle(4'b1110, 1'b0);
      checks++;
      if ({bus.pressed, bus.press, bus.release_pulse} !== {m_pressed, m_press, m_rel}) begin
        errors++;
        $display("FAIL clean_model step=%0d got %b/%b/%b expected %b/%b/%b", i,
                 bus.pressed, bus.press, bus.release_pulse, m_pressed, m_press, m_rel);
      end
      checks++;
      if ({bus.pressed[3:1], bus.press[3:1]} !== 6'b0) begin
        errors++;
        $display("FAIL clean_others step=%0d got pressed=%b press=%b expected upper bits 0",
                 i, bus.pressed, bus.press);
      end
      if (bus.pressed[0] && rise_at < 0) rise_at = i;
      if (bus.press[0]) begin n_press++; press_at = i; end
    end
    checks++;
    if (rise_at !== 6) begin
      errors++;
      $display("FAIL clean_latency got edge %0d expected 6", rise_at);
    end
    checks++;
    if (n_press !== 1 || press_at !== 6) begin
      errors++;
      $display("FAIL clean_pulse got %0d pulses at %0d expected 1 at 6", n_press, press_at);
    end
  endtask

  task automatic test_bounce();
    int rise_j = -1;
    int n_press = 0;
    logic k1;
    for (int j = 0; j < 14; j++) begin
      k1 = (j < 4) ? logic'(j % 2) : 1'b0;
      drive_cycle({2'b11, k1, 1'b0}, 1'b0);
      checks++;
      if ({bus.pressed, bus.press, bus.release_pulse} !== {m_pressed, m_press, m_rel}) begin
        errors++;
        $display("FAIL bounce_model step=%0d got %b/%b/%b expected %b/%b/%b", j,
                 bus.pressed, bus.press, bus.release_pulse, m_pressed, m_press, m_rel);
      end
      if (bus.pressed[1] && rise_j < 0) rise_j = j;
      if (bus.press[1]) n_press++;
    end
    checks++;
    if (rise_j !== 9) begin
      errors++;
      $display("FAIL bounce_latency got step %0d expected 9 (6 edges after last fall)", rise_j);
    end
    checks++;
    if (n_press !== 1) begin
      errors++;
      $display("FAIL bounce_pulses got %0d expected 1", n_press);
    end
  endtask

  task automatic test_release_glitch();
    int rel_j = -1;
    int n_rel = 0;
    logic k2;
    for (int i = 0; i < 8; i++) drive_cycle(4'b1000, 1'b0);
    checks++;
    if (bus.pressed !== 4'b0111) begin
      errors++;
      $display("FAIL release_setup got pressed=%b expected 0111", bus.pressed);
    end
    for (int j = 0; j < 14; j++) begin
      k2 = (j == 2 || j == 3) ? 1'b0 : 1'b1;
      drive_cycle({1'b1, k2, 2'b00}, 1'b0);
      checks++;
      if ({bus.pressed, bus.press, bus.release_pulse} !== {m_pressed, m_press, m_rel}) begin
        errors++;
        $display("FAIL release_model step=%0d got %b/%b/%b expected %b/%b/%b", j,
                 bus.pressed, bus.press, bus.release_pulse, m_pressed, m_press, m_rel);
      end
      if (bus.release_pulse[2]) begin n_rel++; rel_j = j; end
    end
    checks++;
    if (n_rel !== 1 || rel_j !== 9) begin
      errors++;
      $display("FAIL release_pulse got %0d pulses at step %0d expected 1 at 9", n_rel, rel_j);
    end
    checks++;
    if (bus.pressed[2] !== 1'b0) begin
      errors++;
      $display("FAIL release_level got pressed[2]=%b expected 0", bus.pressed[2]);
    end
  endtask

  task automatic test_simultaneous();
    int rise_at[N_KEYS];
    logic [N_KEYS-1:0] press_seen;
    for (int i = 0; i < 10; i++) drive_cycle('1, 1'b0);
    for (int b = 0; b < N_KEYS; b++) rise_at[b] = -1;
    press_seen = '0;
    for (int i = 1; i <= 8; i++) begin
      drive_cycle('0, 1'b0);
      checks++;
      if ({bus.pressed, bus.press, bus.release_pulse} !== {m_pressed, m_press, m_rel}) begin
        errors++;
        $display("FAIL simul_model step=%0d got %b/%b/%b expected %b/%b/%b", i,
                 bus.pressed, bus.press, bus.release_pulse, m_pressed, m_press, m_rel);
      end
      for (int b = 0; b < N_KEYS; b++) if (bus.pressed[b] && rise_at[b] < 0) rise_at[b] = i;
      if (i == 6) press_seen = bus.press;
      if (i == 7) begin
        checks++;
        if (bus.press !== 4'b0000) begin
          errors++;
          $display("FAIL simul_pulse_width got press=%b one cycle later expected 0000", bus.press);
        end
      end
    end
    for (int b = 0; b < N_KEYS; b++) begin
      checks++;
      if (rise_at[b] !== 6) begin
        errors++;
        $display("FAIL simul_rise key=%0d got step %0d expected 6", b, rise_at[b]);
      end
    end
    checks++;
    if (press_seen !== 4'b1111) begin
      errors++;
      $display("FAIL simul_press got %b expected 1111", press_seen);
    end
  endtask

  task automatic test_reset_mid_debounce();
    int rise_at = -1;
    int n_press = 0;
    for (int i = 0; i < 10; i++) drive_cycle('1, 1'b0);
    for (int i = 0; i < 4; i++) drive_cycle(4'b0111, 1'b0);
    drive_cycle(4'b0111, 1'b1);
    checks++;
    if ({bus.pressed, bus.press} !== 8'b0) begin
      errors++;
      $display("FAIL midreset_during got pressed=%b press=%b expected 0000/0000", bus.pressed, bus.press);
    end
    for (int i = 1; i <= 10; i++) begin
      drive_cycle(4'b0111, 1'b0);
      checks++;
      if ({bus.pressed, bus.press, bus.release_pulse} !== {m_pressed, m_press, m_rel}) begin
        errors++;
        $display("FAIL midreset_model step=%0d got %b/%b/%b expected %b/%b/%b", i,
                 bus.pressed, bus.press, bus.release_pulse, m_pressed, m_press, m_rel);
      end
      if (bus.pressed[3] && rise_at < 0) rise_at = i;
      if (bus.press[3]) n_press++;
    end
    checks++;
    if (rise_at !== 6 || n_press !== 1) begin
      errors++;
      $display("FAIL midreset_press got rise at %0d with %0d pulses expected 6 with 1", rise_at, n_press);
    end
  endtask

  task automatic test_random();
    logic [N_KEYS-1:0] k;
    int                hold;
    int                cyc = 0;
    while (cyc < 600) begin
      k    = N_KEYS'($urandom);
      hold = $urandom_range(1, 7);
      for (int h = 0; h < hold; h++) begin
        drive_cycle(k, ($urandom_range(0, 59) == 0));
        cyc++;
        checks++;
        if ({bus.pressed, bus.press, bus.release_pulse} !== {m_pressed, m_press, m_rel}) begin
          errors++;
          $display("FAIL random_model cycle=%0d got %b/%b/%b expected %b/%b/%b", cyc,
                   bus.pressed, bus.press, bus.release_pulse, m_pressed, m_press, m_rel);
        end
        checks++;
        if ((bus.press & bus.release_pulse) !== '0) begin
          errors++;
          $display("FAIL random_exclusive cycle=%0d got press=%b release=%b expected no overlap",
                   cyc, bus.press, bus.release_pulse);
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    @(negedge clk);
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_glitch();
    test_simultaneous();
    test_reset_mid_debounce();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
